// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial link sender among N_REQ requesters.
// The winner's packet/padding are registered onto the sender inputs and the
// enable/ack handshake is held until acknowledged; a watchdog aborts
// transfers that never see an ack.
module serial_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int PACKET_W = 42,
    parameter int PAD_W    = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PACKET_W-1:0] req_packet,
    input  logic [N_REQ*PAD_W-1:0]    req_padding,
    output logic [N_REQ-1:0]          req_done,
    output logic [N_REQ-1:0]          req_err,
    output logic [N_REQ-1:0]          grant,
    output logic                      sender_enable,
    output logic [PACKET_W-1:0]       sender_packet,
    output logic [PAD_W-1:0]          sender_padding,
    input  logic                      sender_ack,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    err_q, err_d;
    logic                enable_q, enable_d;
    logic [PACKET_W-1:0] packet_q, packet_d;
    logic [PAD_W-1:0]    padding_q, padding_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PACKET_W-1:0] pkt_slice [N_REQ];
    logic [PAD_W-1:0]    pad_slice [N_REQ];
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W:0]      cand_sum;
    logic [IDX_W-1:0]    cand_idx;

    // Unpack the flattened per-requester data buses.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign pkt_slice[gi] = req_packet[gi*PACKET_W +: PACKET_W];
            assign pad_slice[gi] = req_padding[gi*PAD_W +: PAD_W];
        end
    endgenerate

    // Round-robin pick: first requester found scanning from ptr+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k + 1);
            if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state logic for the IDLE/SEND/GAP handshake controller.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        enable_d  = enable_q;
        packet_d  = packet_q;
        padding_d = padding_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    packet_d         = pkt_slice[win_idx];
                    padding_d        = pad_slice[win_idx];
                    enable_d         = 1'b1;
                    ptr_d            = win_idx;
                    cnt_d            = '0;
                    state_d          = ST_SEND;
                end
            end
            ST_SEND: begin
                // Ack has priority over a simultaneous watchdog expiry.
                if (sender_ack) begin
                    enable_d = 1'b0;
                    grant_d  = '0;
                    done_d   = grant_q;
                    state_d  = ST_GAP;
                end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    enable_d = 1'b0;
                    grant_d  = '0;
                    err_d    = grant_q;
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            enable_q  <= 1'b0;
            packet_q  <= '0;
            padding_q <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            enable_q  <= enable_d;
            packet_q  <= packet_d;
            padding_q <= padding_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant          = grant_q;
    assign req_done       = done_q;
    assign req_err        = err_q;
    assign sender_enable  = enable_q;
    assign sender_packet  = packet_q;
    assign sender_padding = padding_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one serial link sender (enable/ack handshake, 42-bit packet plus 4-bit padding) among N_REQ requesters, such as NoC router output ports.
- Arbitrates round-robin and registers the winner's packet and padding onto the sender inputs.
- Holds the handshake until the sender acknowledges.
- A watchdog aborts a transfer that is never acknowledged.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- PACKET_W, 42, packet width.
- PAD_W, 4, padding width.
- TIMEOUT, 1024, maximum SEND cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester level request; held high with stable data until req_done or req_err.
- req_packet  in  N_REQ*PACKET_W  flattened packets; requester i uses bits [i*PACKET_W +: PACKET_W].
- req_padding  in  N_REQ*PAD_W  flattened padding, same slicing.
- req_done  out  N_REQ  one-cycle pulse to the granted requester when its transfer is acknowledged.
- req_err  out  N_REQ  one-cycle pulse to the granted requester on watchdog abort.
- grant  out  N_REQ  one-hot, high while the requester owns the link.
- sender_enable  out  1  request to the serial sender.
- sender_packet  out  PACKET_W  registered packet.
- sender_padding  out  PAD_W  registered padding.
- sender_ack  in  1  sender completion pulse.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. All outputs are 0: grant, req_done, req_err, sender_enable, sender_packet, sender_padding, busy. RR pointer=N_REQ-1, so requester 0 wins first. Watchdog counter=0. Reset mid-transfer aborts silently with no done/err pulse; any in-flight sender_ack after reset is ignored.
- The state machine has three states: IDLE, SEND, GAP.
- IDLE, any req high at edge t:
  - Winner = first set bit scanning ptr+1, ptr+2, ... modulo N_REQ.
  - At edge t the block registers grant=onehot(winner), sender_packet/sender_padding from the winner's slice, sender_enable=1, ptr=winner, counter=0, state=SEND.
  - Latency from req to sender_enable is 1 cycle.
- IDLE with no req: outputs hold; sender_ack is ignored.
- SEND: sender_enable stays 1, and sender_packet/sender_padding stay stable (no re-sampling of req_packet). The counter increments every cycle.
  - sender_ack=1: next edge sets sender_enable=0, grant=0, req_done[winner]=1 (for one cycle), state=GAP.
  - No ack and counter==TIMEOUT-1 (TIMEOUT>0): next edge sets sender_enable=0, grant=0, req_err[winner]=1 (for one cycle), state=GAP.
  - Ack and timeout in the same cycle: ack wins; req_done pulses and req_err does not.
  - req dropping during SEND is ignored; the transfer still completes or aborts normally.
- GAP: exactly one cycle. req_done/req_err clear, sender_enable stays 0, then state=IDLE. sender_ack in GAP is ignored.
  - Consequence: sender_enable is low for at least 2 cycles between packets (GAP plus the IDLE arbitration cycle).
  - A requester whose req is still high after its done pulse is treated as a new request and is arbitrated fairly.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,...,N_REQ-1,0,... A winner cannot win again while another requester is waiting.
- sender_packet and sender_padding retain their last value after the transfer (no clearing).
- busy = (state != IDLE).

Test Plan:
- Single request:
  - Stimulus: reset, release; req=0001 with packet 42'h2AC19440329, padding 4'b1011; sender model acks 20 cycles after enable.
  - Required response: sender_enable rises 1 cycle after req; sender_packet=42'h2AC19440329 and sender_padding=4'hB, held stable; one req_done[0] pulse; grant returns to 0.
- Round-robin:
  - Stimulus: req=1111 held continuously, distinct packets per requester.
  - Required response: grant order 0,1,2,3,0; each sender_packet matches its grantee; enable-low gap of at least 2 cycles between packets.
- Pointer continuation:
  - Stimulus: requester 2 served; then req=0101.
  - Required response: requester 0 wins next (scan starts at 3), then requester 2.
- Watchdog:
  - Stimulus: TIMEOUT=16, sender never acks.
  - Required response: req_err[winner] pulses after 16 SEND cycles; sender_enable drops; state returns to IDLE.
  - Second stimulus: ack asserted in the same cycle the counter hits 15.
  - Required response: req_done pulses and req_err does not.
- Reset mid-transfer:
  - Stimulus: rst for 1 cycle during SEND, then a late sender_ack.
  - Required response: all outputs are 0 the cycle after reset; no done/err pulse; the late ack is ignored; the next arbitration grants requester 0 first.
